// File: rtl/spi_slave.sv
// SPI slave front-end for the single-port RAM: deserialises 10-bit MOSI commands, serialises RAM read bytes onto MISO.
// Define SPI_SLAVE_CHECK_EN to add the frame_err port and drop completed frames whose op bits do not match the state.
module spi_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       MOSI,
  input  logic       SS_n,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
`ifdef SPI_SLAVE_CHECK_EN
  ,
  output logic       frame_err
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // All registered state lives in one struct so a checker can bind to a single signal.
  typedef struct packed {
    state_t     state;
    logic       rd_addr_ok;
    logic [3:0] rx_cnt;
    logic [8:0] rx_shift;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       rd_wait;
    logic       tx_busy;
    logic [3:0] tx_cnt;
    logic [7:0] tx_shift;
    logic       miso;
`ifdef SPI_SLAVE_CHECK_EN
    logic       frame_err;
`endif
  } spi_regs_t;

  spi_regs_t  q;
  spi_regs_t  d;
  logic [9:0] frame_word;
  logic       op_ok;

  assign frame_word = {q.rx_shift, MOSI};

`ifdef SPI_SLAVE_CHECK_EN
  // WRITE accepts ops 00/01, READ_ADD only 10, READ_DATA only 11.
  assign op_ok = (q.state == WRITE)    ? ~frame_word[9] :
                 (q.state == READ_ADD) ? (frame_word[9:8] == 2'b10) :
                                         (frame_word[9:8] == 2'b11);
`else
  assign op_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

  always_comb begin
    d          = q;
    d.rx_valid = 1'b0;
`ifdef SPI_SLAVE_CHECK_EN
    d.frame_err = 1'b0;
`endif
    if (SS_n && (q.state != IDLE)) begin
      // Deselect: drop any partial frame or shift-out, keep rd_addr_ok and rx_data.
      d.state   = IDLE;
      d.rx_cnt  = 4'd0;
      d.tx_cnt  = 4'd0;
      d.rd_wait = 1'b0;
      d.tx_busy = 1'b0;
      d.miso    = 1'b0;
    end else begin
      case (q.state)
        IDLE: begin
          if (!SS_n) d.state = CHK_CMD;
        end
        CHK_CMD: begin
          if (!MOSI)             d.state = WRITE;
          else if (q.rd_addr_ok) d.state = READ_DATA;
          else                   d.state = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (q.rx_cnt < 4'd10) begin
            d.rx_shift = {q.rx_shift[7:0], MOSI};
            d.rx_cnt   = q.rx_cnt + 4'd1;
            if (q.rx_cnt == 4'd9) begin
              if (op_ok) begin
                d.rx_data  = frame_word;
                d.rx_valid = 1'b1;
                if (q.state == READ_ADD)  d.rd_addr_ok = 1'b1;
                if (q.state == READ_DATA) d.rd_wait    = 1'b1;
              end else begin
`ifdef SPI_SLAVE_CHECK_EN
                d.frame_err = 1'b1;
`endif
              end
            end
          end else if (q.rd_wait) begin
            if (tx_valid) begin
              d.tx_shift   = tx_data;
              d.rd_addr_ok = 1'b0;
              d.rd_wait    = 1'b0;
              d.tx_busy    = 1'b1;
              d.tx_cnt     = 4'd0;
            end
          end else if (q.tx_busy) begin
            // Eight data bits, then one edge that returns MISO to 0.
            if (q.tx_cnt == 4'd8) begin
              d.miso    = 1'b0;
              d.tx_busy = 1'b0;
            end else begin
              d.miso     = q.tx_shift[7];
              d.tx_shift = {q.tx_shift[6:0], 1'b0};
              d.tx_cnt   = q.tx_cnt + 4'd1;
            end
          end
        end
        default: d.state = IDLE;
      endcase
    end
  end

  assign MISO     = q.miso;
  assign rx_data  = q.rx_data;
  assign rx_valid = q.rx_valid;
`ifdef SPI_SLAVE_CHECK_EN
  assign frame_err = q.frame_err;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave: frames are described at transaction level and expected
// outputs come from edge-indexed rules (E0 select, E1 routing, E2..E11 data, tx shift after Tk).
module tb_spi_slave;

`ifdef SPI_SLAVE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       MOSI;
  logic       SS_n;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_SLAVE_CHECK_EN
  logic       frame_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic       m_rd_ok = 1'b0;
  logic [9:0] m_rx    = 10'h000;
  logic [9:0] exp_q[$];

  spi_slave dut (
    .clk      (clk),
    .rst      (rst),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_SLAVE_CHECK_EN
    ,
    .frame_err(frame_err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic op_legal(input int kind, input logic [1:0] op);
    case (kind)
      0:       return ~op[1];
      1:       return op == 2'b10;
      default: return op == 2'b11;
    endcase
  endfunction

  // driver: one clock edge with the given pin values, sampled 1 time unit after the edge
  task automatic tick(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
    @(negedge clk);
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = txv;
    tx_data  = txd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_edge(input logic ev, input logic [9:0] ed, input logic em);
    check("rx_valid", rx_valid, ev);
    check("rx_data", rx_data, ed);
    check("miso", MISO, em);
    if (rx_valid === 1'b1) begin
      if (exp_q.size() == 0) check("rx_unexpected", 1, 0);
      else                   check("rx_scoreboard", rx_data, exp_q.pop_front());
    end
  endtask

  // One SS_n-low window of `low` edges followed by one deselect edge.
  task automatic run_frame(input logic route, input logic [9:0] bits, input int low,
                           input int tx_early, input int tx_at, input logic [7:0] txd,
                           input int rst_at);
    int   kind;
    logic ok, done, acc, ev, em, mosi, txv;
    kind = (route == 1'b0) ? 0 : (m_rd_ok ? 2 : 1);
    ok   = !CHECK_EN || op_legal(kind, bits[9:8]);
    done = (low >= 12);
    acc  = done && ok && (kind == 2) && (tx_at >= 12) && (tx_at < low);
    for (int e = 0; e < low; e++) begin
      if (e == 1)                mosi = route;
      else if (e >= 2 && e <= 11) mosi = bits[11-e];
      else                       mosi = 1'($urandom_range(0, 1));
      txv = (e == tx_early) || (e == tx_at);
      tick(1'b0, mosi, txv, txv ? txd : 8'($urandom_range(0, 255)));
      ev = (e == 11) && done && ok;
      if (ev) begin
        m_rx = bits;
        exp_q.push_back(bits);
      end
      em = 1'b0;
      if (acc && e > tx_at && e <= tx_at + 8) em = txd[7-(e-tx_at-1)];
      check_edge(ev, m_rx, em);
`ifdef SPI_SLAVE_CHECK_EN
      check("frame_err", frame_err, (e == 11) && done && !ok);
`endif
      if (e == rst_at) begin
        #1 rst = 1'b0;
        #1;
        m_rx = 10'h000;
        m_rd_ok = 1'b0;
        exp_q.delete();
        check("rst_miso", MISO, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        @(negedge clk);
        rst  = 1'b1;
        SS_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        check_edge(1'b0, m_rx, 1'b0);
        return;
      end
    end
    if (done && ok && kind == 1) m_rd_ok = 1'b1;
    if (acc)                     m_rd_ok = 1'b0;
    tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
    check_edge(1'b0, m_rx, 1'b0);
  endtask

  initial begin
    int kind, low, tx_at, tx_early, r;
    logic route;
    logic [1:0] op;
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    #2 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_miso", MISO, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
`ifdef SPI_SLAVE_CHECK_EN
    check("reset_frame_err", frame_err, 0);
`endif
    @(negedge clk) rst = 1'b1;

    // directed: write address, write data, read address, read data, abort, recovery
    run_frame(1'b0, 10'h005, 12, -1, -1, 8'h00, -1);
    run_frame(1'b0, 10'h1AA, 14,  5, 13, 8'h3C, -1);
    run_frame(1'b1, 10'h205, 12, -1, -1, 8'h00, -1);
    run_frame(1'b1, 10'h300, 23,  9, 13, 8'hAA, -1);
    run_frame(1'b0, 10'h0AB,  8, -1, -1, 8'h00, -1);
    run_frame(1'b0, 10'h0C3, 12, -1, -1, 8'h00, -1);
    // op mismatch: dropped with frame_err when checking is built in, forwarded otherwise
    run_frame(1'b0, 10'h301, 12, -1, -1, 8'h00, -1);

    // randomised frames
    for (int i = 0; i < 80; i++) begin
      route = 1'($urandom_range(0, 1));
      kind  = (route == 1'b0) ? 0 : (m_rd_ok ? 2 : 1);
      if ($urandom_range(0, 3) != 0)
        op = (kind == 0) ? {1'b0, 1'($urandom_range(0, 1))} : (kind == 1) ? 2'b10 : 2'b11;
      else
        op = 2'($urandom_range(0, 3));
      tx_at    = $urandom_range(12, 15);
      tx_early = ($urandom_range(0, 1) != 0) ? $urandom_range(2, 11) : -1;
      r = $urandom_range(0, 9);
      if (r == 0)         low = $urandom_range(2, 11);
      else if (kind == 2) low = tx_at + $urandom_range(0, 12);
      else                low = 12 + $urandom_range(0, 4);
      run_frame(route, {op, 8'($urandom_range(0, 255))}, low, tx_early, tx_at,
                8'($urandom_range(0, 255)), -1);
    end

    // reset during READ_DATA shift-out, then a routing 1 must select READ_ADD again
    if (!m_rd_ok) run_frame(1'b1, 10'h211, 12, -1, -1, 8'h00, -1);
    run_frame(1'b1, 10'h3FF, 30, -1, 12, 8'hFF, 16);
    run_frame(1'b1, 10'h207, 14, -1, 12, 8'h81, -1);
    run_frame(1'b1, 10'h300, 24, -1, 13, 8'h5A, -1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
